// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu_if
// Purpose  : req/gnt/rvalid data-memory bus between the MEM-stage LSU and memory.
// Revision : 1.0  initial release
// ============================================================================
interface mem_stage_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int c_numBytes = XLEN / 8;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [c_numBytes-1:0] mem_be;
    logic [XLEN-1:0]       mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [XLEN-1:0]       mem_rdata;
    logic                  mem_err;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : MEM-stage load/store unit: lane steering, load extension, bus FSM.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              lsu_valid,
    input  wire logic              lsu_we,
    input  wire logic [2:0]        lsu_funct3,
    input  wire logic [ADDR_W-1:0] lsu_addr,
    input  wire logic [XLEN-1:0]   lsu_wdata,
    output logic                   lsu_stall,
    output logic                   lsu_done,
    output logic [XLEN-1:0]        lsu_rdata,
    output logic                   lsu_misalign,
    output logic                   lsu_buserr,
    mem_stage_lsu_if.master        bus
);
    localparam int       c_numBytes = XLEN / 8;
    localparam int       c_offW     = $clog2(c_numBytes);
    localparam bit       c_is64     = (XLEN == 64);
    localparam bit [7:0] c_tmoLast  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } stateT;

    stateT                 r_state;
    stateT                 w_nextState;
    logic [7:0]            r_count;
    logic                  r_isMis;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [c_numBytes-1:0] r_be;
    logic [XLEN-1:0]       r_wdata;
    logic [2:0]            r_funct3;
    logic [c_offW-1:0]     r_off;
    logic [XLEN-1:0]       r_rdata;

    logic [c_offW-1:0]     w_off;
    logic [c_offW-1:0]     w_alignMask;
    logic [c_numBytes-1:0] w_beMask;
    logic                  w_legal;
    logic                  w_tmo;
    logic [XLEN-1:0]       w_shifted;
    logic [XLEN-1:0]       w_ext;

    assign w_off = lsu_addr[c_offW-1:0];

    always_comb begin
        w_alignMask = '0;
        w_beMask    = '0;
        case (lsu_funct3[1:0])
            2'b00: begin
                w_alignMask = '0;
                w_beMask    = c_numBytes'(8'h01);
            end
            2'b01: begin
                w_alignMask = c_offW'(3'd1);
                w_beMask    = c_numBytes'(8'h03);
            end
            2'b10: begin
                w_alignMask = c_offW'(3'd3);
                w_beMask    = c_numBytes'(8'h0F);
            end
            default: begin
                w_alignMask = c_offW'(3'd7);
                w_beMask    = c_numBytes'(8'hFF);
            end
        endcase
    end

    // Doubleword and lwu only exist on RV64; stores have no unsigned forms.
    assign w_legal = (lsu_funct3 != 3'b111)
                   && (c_is64 || (lsu_funct3[1:0] != 2'b11))
                   && (c_is64 || (lsu_funct3 != 3'b110))
                   && !(lsu_we && lsu_funct3[2])
                   && ((w_off & w_alignMask) == '0);

    assign w_tmo = (r_count >= c_tmoLast);

    assign w_shifted = bus.mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_shifted;
        case (r_funct3[1:0])
            2'b00: begin
                if (r_funct3[2]) w_ext = XLEN'(w_shifted[7:0]);
                else             w_ext = XLEN'($signed(w_shifted[7:0]));
            end
            2'b01: begin
                if (r_funct3[2]) w_ext = XLEN'(w_shifted[15:0]);
                else             w_ext = XLEN'($signed(w_shifted[15:0]));
            end
            2'b10: begin
                if (r_funct3[2]) w_ext = XLEN'(w_shifted[31:0]);
                else             w_ext = XLEN'($signed(w_shifted[31:0]));
            end
            default: w_ext = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_isMis  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_IDLE && lsu_valid) begin
                r_count <= '0;
                r_isMis <= !w_legal;
                if (w_legal) begin
                    r_we     <= lsu_we;
                    r_addr   <= {lsu_addr[ADDR_W-1:c_offW], c_offW'(0)};
                    r_be     <= w_beMask << w_off;
                    r_wdata  <= lsu_wdata << {w_off, 3'b000};
                    r_funct3 <= lsu_funct3;
                    r_off    <= w_off;
                end
            end
            if ((r_state == S_REQ || r_state == S_WAIT) && r_count != 8'hFF) begin
                r_count <= r_count + 8'd1;
            end
            if (r_state == S_WAIT && bus.mem_rvalid && !bus.mem_err) begin
                r_rdata <= w_ext;
            end
        end
    end

    // A grant in the final counted cycle still wins so the response is not orphaned.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu_valid) w_nextState = w_legal ? S_REQ : S_ERR;
            end
            S_REQ: begin
                if (bus.mem_gnt) w_nextState = S_WAIT;
                else if (w_tmo)  w_nextState = S_ERR;
            end
            S_WAIT: begin
                if (bus.mem_rvalid) w_nextState = bus.mem_err ? S_ERR : S_DONE;
                else if (w_tmo)     w_nextState = S_ERR;
            end
            S_DONE:  w_nextState = S_IDLE;
            S_ERR:   w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        lsu_stall    = 1'b0;
        lsu_done     = 1'b0;
        lsu_misalign = 1'b0;
        lsu_buserr   = 1'b0;
        case (r_state)
            S_IDLE:  lsu_stall = lsu_valid;
            S_REQ:   lsu_stall = 1'b1;
            S_WAIT:  lsu_stall = 1'b1;
            S_DONE:  lsu_done  = 1'b1;
            S_ERR: begin
                lsu_misalign = r_isMis;
                lsu_buserr   = !r_isMis;
            end
            default: lsu_stall = 1'b0;
        endcase
    end

    assign lsu_rdata     = r_rdata;
    assign bus.mem_req   = (r_state == S_REQ);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_be    = r_be;
    assign bus.mem_wdata = r_wdata;
endmodule
`default_nettype wire
